// File: rtl/multiplexer_n_to_1_stream_pkg.sv
`timescale 1ns/100ps
// Shared constants for the N-to-1 stream multiplexer: selection-mode codes and
// a helper that folds any unsupported MODE value back to external steering.
package multiplexer_n_to_1_stream_pkg;

  localparam int MUX_MODE_EXTERNAL    = 0;
  localparam int MUX_MODE_ROUND_ROBIN = 1;

  function automatic int resolveMode(input int mode);
    return (mode == MUX_MODE_ROUND_ROBIN) ? MUX_MODE_ROUND_ROBIN : MUX_MODE_EXTERNAL;
  endfunction

endpackage

// File: rtl/multiplexer_n_to_1_stream_round_robin_arbiter.sv
`timescale 1ns/100ps
// Combinational round-robin arbiter: grants the first requesting channel found
// after last_grant, wrapping around, so every requester is served in turn.
module round_robin_arbiter
  import multiplexer_n_to_1_stream_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [CHANNELS-1:0]  request,
  input  logic [SEL_WIDTH-1:0] last_grant,
  input  logic                 enable,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  // Scan distances 1..CHANNELS from the previous winner; the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (enable && !grant_valid && request[i] &&
            (i == ((int'(last_grant) + k) % CHANNELS))) begin
          grant       = SEL_WIDTH'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multiplexer_n_to_1_stream.sv
`timescale 1ns/100ps
// N-to-1 valid/ready stream multiplexer with a one-entry registered output;
// the source is steered externally (MODE=0) or chosen round-robin (MODE=1).
module multiplexer_n_to_1_stream
  import multiplexer_n_to_1_stream_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int MODE       = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] input_signal,
  input  logic [CHANNELS-1:0]            input_valid,
  output logic [CHANNELS-1:0]            input_ready,
  input  logic [SEL_WIDTH-1:0]           selection,
  output logic [DATA_WIDTH-1:0]          output_signal,
  output logic                           output_valid,
  input  logic                           output_ready,
  output logic [SEL_WIDTH-1:0]           output_channel
);

  localparam int EffectiveMode = resolveMode(MODE);
  localparam int SelRange      = 2 ** SEL_WIDTH;

  logic                  loadEn;
  logic                  grantValid;
  logic                  transfer;
  logic [SEL_WIDTH-1:0]  grantIdx;
  logic [DATA_WIDTH-1:0] grantData;

  logic                  outValid_q,   outValid_d;
  logic [DATA_WIDTH-1:0] outSignal_q,  outSignal_d;
  logic [SEL_WIDTH-1:0]  outChannel_q, outChannel_d;

  generate
    if (EffectiveMode == MUX_MODE_ROUND_ROBIN) begin : gRoundRobin
      logic [SEL_WIDTH-1:0] lastGrant_q, lastGrant_d;

      round_robin_arbiter #(
        .CHANNELS  (CHANNELS),
        .SEL_WIDTH (SEL_WIDTH)
      ) uArbiter (
        .request     (input_valid),
        .last_grant  (lastGrant_q),
        .enable      (!reset),
        .grant       (grantIdx),
        .grant_valid (grantValid)
      );

      // The pointer moves only when a beat is actually taken, so stalls keep priority order.
      always_comb begin
        lastGrant_d = transfer ? grantIdx : lastGrant_q;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          lastGrant_q <= SEL_WIDTH'(CHANNELS - 1);
        end else begin
          lastGrant_q <= lastGrant_d;
        end
      end
    end else begin : gExternal
      // Widening to the full selection range lets an out-of-range select read a zero.
      logic [SelRange-1:0] validExt;
      assign validExt   = SelRange'(input_valid);
      assign grantIdx   = selection;
      assign grantValid = !reset && (int'(selection) < CHANNELS) && validExt[selection];
    end
  endgenerate

  assign loadEn   = !outValid_q || output_ready;
  assign transfer = loadEn && grantValid;

  always_comb begin
    input_ready = '0;
    grantData   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grantIdx) == i) begin
        input_ready[i] = transfer;
        grantData      = input_signal[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A new beat takes priority over draining, giving back-to-back beats with no bubble.
  always_comb begin
    outValid_d   = outValid_q;
    outSignal_d  = outSignal_q;
    outChannel_d = outChannel_q;
    if (transfer) begin
      outValid_d   = 1'b1;
      outSignal_d  = grantData;
      outChannel_d = grantIdx;
    end else if (outValid_q && output_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid_q   <= 1'b0;
      outSignal_q  <= '0;
      outChannel_q <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outSignal_q  <= outSignal_d;
      outChannel_q <= outChannel_d;
    end
  end

  assign output_valid   = outValid_q;
  assign output_signal  = outSignal_q;
  assign output_channel = outChannel_q;

endmodule

// File: doc/multiplexer_n_to_1_stream.md
Name: multiplexer_n_to_1_stream

Overview:
- Parametrised successor to the gate-level 2-to-1 multiplexer: selects one of CHANNELS input streams onto a single registered output stream.
- Each port uses a valid/ready handshake.
- Two selection modes:
  - MODE=0: externally steered; the selection port is honoured as in the 2-to-1 block.
  - MODE=1: internal round-robin arbitration among valid channels.
- Sits between several producer blocks and one shared consumer (bus, serialiser, FIFO).

Parameters:
- CHANNELS, 4, number of input channels; legal range 2..16.
- DATA_WIDTH, 8, bits per data beat.
- SEL_WIDTH, 2, width of selection and out_channel; must satisfy 2**SEL_WIDTH >= CHANNELS.
- MODE, 0, 0 = external selection, 1 = round-robin arbitration.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- input_signal  input  CHANNELS*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- input_valid  input  CHANNELS  per-channel valid.
- input_ready  output  CHANNELS  per-channel ready; at most one bit set.
- selection  input  SEL_WIDTH  channel select; used only when MODE=0.
- output_signal  output  DATA_WIDTH  registered output data.
- output_valid  output  1  output beat present.
- output_ready  input  1  consumer accepts the beat.
- output_channel  output  SEL_WIDTH  index of the channel that produced the current output beat.

Behaviour:
- Reset (asynchronous, active-high):
  - output_valid=0, output_signal=0, output_channel=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has first priority.
  - input_ready is all 0 while reset is high.
- Storage and load:
  - One-entry output register; no skid buffer.
  - load_en = !output_valid || output_ready.
- Grant (combinational):
  - MODE=0: grant = selection when selection < CHANNELS and input_valid[selection]=1; otherwise no grant. Out-of-range selection never grants and never hangs; it simply stalls.
  - MODE=1: grant = the first channel with input_valid set, searching (last_grant+1) mod CHANNELS, then +2, and so on, wrapping. No grant if input_valid is all 0.
- Handshake:
  - input_ready[i] = load_en && grant_valid && (grant==i).
  - input_ready must not depend combinationally on input_valid of any other channel in MODE=0.
  - An input transfer occurs on a clock edge where input_valid[i] && input_ready[i].
- Per-edge register update:
  - Input transfer: output_signal <= channel data, output_channel <= i, output_valid <= 1. In MODE=1, last_grant <= i.
  - Else if output_valid && output_ready: output_valid <= 0. output_signal and output_channel hold their last values.
  - Else: hold all registers.
- Latency: 1 cycle from input transfer to output_valid.
- Throughput: 1 beat/cycle while output_ready is held high.
- Back-pressure: output_valid=1 and output_ready=0 gives input_ready all 0. The output beat and output_channel must stay stable until accepted.
- Simultaneous output accept and new input transfer in the same cycle: the new beat replaces the old one; output_valid stays 1 with no bubble.
- Arbitration details:
  - The round-robin pointer advances only on a transfer, never on idle or stalled cycles.
  - Fairness: with all channels continuously valid, grants cycle 0,1,...,CHANNELS-1,0 with no channel granted twice before every other valid channel is granted once.
- Selection changes in MODE=0 take effect in the same cycle, with no registering. A held output beat is unaffected by later selection changes.
- Reset asserted mid-operation: the held beat is discarded, outputs return immediately to reset values, and no input transfer is recorded on that edge.
- MODE is static. Any parameter other than 0 or 1 is treated as 0.

Decomposition:
- Shared include file multiplexer_defines.vh, guarded by an include guard. It holds:
  - Mode constants MUX_MODE_EXTERNAL=0 and MUX_MODE_ROUND_ROBIN=1.
  - Timescale 1ns/100ps.
- One natural sub-module: round_robin_arbiter.
  - Parameter CHANNELS.
  - Inputs: request[CHANNELS], last_grant, enable.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
  - Instantiated only when MODE=1 via a generate branch.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle with output_valid=1 -> output_valid, output_signal and output_channel go to 0 immediately; input_ready=0000.
2. MODE=0, CHANNELS=4, DATA_WIDTH=8: selection=2, input_valid=0100, channel 2 data=8'hA5, output_ready=1 -> input_ready=0100; next cycle output_signal=A5, output_channel=2, output_valid=1.
3. MODE=0: selection=2, input_valid=0000, then selection=3 (in range, not valid) -> no transfer and input_ready=0000. Repeat with CHANNELS=3 and selection=3 (out of range) -> same result, no transfer.
4. Back-pressure: output_valid=1 with output_ready=0 for 5 cycles -> output_signal and output_channel stable, input_ready=0000. Raise output_ready with a new valid input -> back-to-back beats with no bubble.
5. MODE=1: all four channels valid continuously, output_ready=1, data = channel index -> output sequence 00,01,02,03,00,01, with output_channel matching.
6. MODE=1: only channels 1 and 3 valid, output_ready toggling 1/0 -> grants alternate 1,3,1,3; the pointer does not advance on stalled cycles.
